// File: rtl/mix_engine_p_pkg.sv
// Shared types and constants for the mixing engine: FSM states, mode-bit
// positions and the lane offsets each round stage reads from.
package mix_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int MODE_INC = 0;
  localparam int MODE_ADD = 1;
  localparam int MODE_XOR = 2;
  localparam int MODE_SHR = 3;

  localparam int ADD_P   = 1;
  localparam int ADD_M   = 5;
  localparam int XOR_OFF = 3;
  localparam int SHR_A   = 2;
  localparam int SHR_B   = 4;

endpackage

// File: rtl/mix_engine_p_if.sv
// Job/result bundle between a control block (master) and the engine (slave).
// out_ready is the only consumer-side backpressure; start is only honoured when idle.
interface mix_engine_p_if #(
  parameter int LANES  = 8,
  parameter int WIDTH  = 32,
  parameter int RCNT_W = 8
);
  logic                   start;
  logic [LANES*WIDTH-1:0] seed;
  logic [RCNT_W-1:0]      rounds;
  logic [3:0]             mode;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] result;

  modport master (
    output start, seed, rounds, mode, out_ready,
    input  busy, out_valid, result
  );

  modport slave (
    input  start, seed, rounds, mode, out_ready,
    output busy, out_valid, result
  );
endinterface

// File: rtl/mix_engine_p_round.sv
// One mixing round, purely combinational (zero latency, no backpressure).
// Stages INC, ADD, XOR, SHR in order; each stage updates lanes in place, low index first.
module mix_round
  import mix_engine_pkg::*;
#(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int SHL   = 16,
  parameter int SR1   = 17,
  parameter int SR2   = 12
) (
  input  logic [LANES*WIDTH-1:0] vec,
  input  logic [3:0]             mode,
  output logic [LANES*WIDTH-1:0] nxt
);

  always_comb begin
    logic [LANES*WIDTH-1:0] o;
    o = vec;
    if (mode[MODE_INC]) begin
      for (int i = 0; i < LANES; i++)
        o[i*WIDTH +: WIDTH] = o[i*WIDTH +: WIDTH] + WIDTH'(i);
    end
    // Later lanes deliberately see earlier lanes already updated in this stage.
    if (mode[MODE_ADD]) begin
      for (int i = 0; i < LANES; i++)
        o[i*WIDTH +: WIDTH] = o[i*WIDTH +: WIDTH]
                            + o[((i + ADD_P) % LANES)*WIDTH +: WIDTH]
                            - o[((i + ADD_M) % LANES)*WIDTH +: WIDTH];
    end
    if (mode[MODE_XOR]) begin
      for (int i = 0; i < LANES; i++)
        o[i*WIDTH +: WIDTH] = o[i*WIDTH +: WIDTH]
                            ^ (o[((i + XOR_OFF) % LANES)*WIDTH +: WIDTH] << SHL);
    end
    if (mode[MODE_SHR]) begin
      for (int i = 0; i < LANES; i++)
        o[i*WIDTH +: WIDTH] = o[i*WIDTH +: WIDTH]
                            - (o[((i + SHR_A) % LANES)*WIDTH +: WIDTH] >> SR1)
                            + (o[((i + SHR_B) % LANES)*WIDTH +: WIDTH] >> SR2);
    end
    nxt = o;
  end

endmodule

// File: rtl/mix_engine_p.sv
// Iterative mixer: loads seed on start, one round per clock, result valid R clocks after start.
// Result is held with out_valid until out_ready; start is ignored while busy (not queued).
module mix_engine_p
  import mix_engine_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int WIDTH  = 32,
  parameter int RCNT_W = 8,
  parameter int SHL    = 16,
  parameter int SR1    = 17,
  parameter int SR2    = 12
) (
  input logic         clk,
  input logic         rst,
  mix_engine_p_if.slave bus
);

  state_t                 state;
  logic [LANES*WIDTH-1:0] lanes;
  logic [LANES*WIDTH-1:0] lanes_nxt;
  logic [RCNT_W-1:0]      count;
  logic [3:0]             mode_r;
  logic                   busy_r;
  logic                   valid_r;

  mix_round #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .SHL   (SHL),
    .SR1   (SR1),
    .SR2   (SR2)
  ) u_round (
    .vec  (lanes),
    .mode (mode_r),
    .nxt  (lanes_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lanes   <= '0;
      count   <= '0;
      mode_r  <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            lanes  <= bus.seed;
            mode_r <= bus.mode;
            count  <= bus.rounds;
            busy_r <= 1'b1;
            // A zero-round job skips RUN and presents the seed directly.
            if (bus.rounds == '0) begin
              state   <= HOLD;
              valid_r <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          lanes <= lanes_nxt;
          count <= count - RCNT_W'(1);
          if (count == RCNT_W'(1)) begin
            state   <= HOLD;
            valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.out_valid = valid_r;
  assign bus.result    = lanes;

endmodule

// File: tb/tb_mix_engine_p.sv
// Randomised scoreboard bench for mix_engine_p against an array-based reference model.
module tb_mix_engine_p;

  localparam int L = 8;
  localparam int W = 32;
  typedef logic [L*W-1:0] vec_t;
  typedef struct {
    vec_t res;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mix_engine_p_if #(.LANES(L), .WIDTH(W), .RCNT_W(8)) bus ();

  mix_engine_p #(
    .LANES(L), .WIDTH(W), .RCNT_W(8), .SHL(16), .SR1(17), .SR2(12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the round rules applied to a plain lane array.
  function automatic vec_t model(input vec_t s, input logic [3:0] m, input int r);
    logic [W-1:0] o[L];
    vec_t v;
    for (int i = 0; i < L; i++) o[i] = s[i*W +: W];
    for (int k = 0; k < r; k++) begin
      if (m[0]) for (int i = 0; i < L; i++) o[i] = o[i] + W'(i);
      if (m[1]) for (int i = 0; i < L; i++) o[i] = o[i] + o[(i+1)%L] - o[(i+5)%L];
      if (m[2]) for (int i = 0; i < L; i++) o[i] = o[i] ^ (o[(i+3)%L] << 16);
      if (m[3]) for (int i = 0; i < L; i++) o[i] = o[i] - (o[(i+2)%L] >> 17) + (o[(i+4)%L] >> 12);
    end
    for (int i = 0; i < L; i++) v[i*W +: W] = o[i];
    return v;
  endfunction

  // Monitor: first valid cycle checks latency, every valid cycle checks the result.
  logic seen = 1'b0;
  logic have_exp = 1'b0;
  vec_t cur_exp;
  always @(negedge clk) begin
    if (rst || !bus.out_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          have_exp = 1'b0;
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got out_valid=1 at cycle %0d expected no job", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          have_exp = 1'b1;
          cur_exp = e.res;
          check("latency", vec_t'(cyc), vec_t'(e.cyc));
        end
      end
      if (have_exp) check("result", bus.result, cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t s, input logic [3:0] m, input int r,
                       input vec_t exp, input logic ready_hi);
    int n = 0;
    exp_t e;
    while (bus.busy && n < 50) begin tick(); n++; end
    check("idle_before_start", vec_t'(bus.busy), vec_t'(0));
    bus.seed = s;
    bus.mode = m;
    bus.rounds = 8'(r);
    bus.out_ready = ready_hi;
    bus.start = 1'b1;
    e.res = exp;
    e.cyc = cyc + 1 + r;
    exp_q.push_back(e);
    tick();
    bus.start = 1'b0;
    bus.seed = {8{$urandom}};
    bus.mode = 4'($urandom);
    bus.rounds = 8'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 300) begin tick(); n++; end
    if (!bus.out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got out_valid=0 after %0d cycles expected 1", n);
    end
  endtask

  task automatic run_job(input vec_t s, input logic [3:0] m, input int r,
                         input vec_t exp, input int stall);
    issue(s, m, r, exp, stall < 0);
    wait_valid();
    for (int k = 0; k < stall; k++) begin
      check("hold_busy", vec_t'(bus.busy), vec_t'(1));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_busy", vec_t'(bus.busy), vec_t'(0));
    check("post_valid", vec_t'(bus.out_valid), vec_t'(0));
    check("post_result", bus.result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t s, e;
    bus.start = 1'b0;
    bus.seed = '0;
    bus.rounds = '0;
    bus.mode = '0;
    bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", vec_t'(bus.busy), vec_t'(0));
    check("reset_valid", vec_t'(bus.out_valid), vec_t'(0));
    check("reset_result", bus.result, '0);

    // INC only, five rounds: lane i = 5*i.
    for (int i = 0; i < L; i++) e[i*W +: W] = W'(5 * i);
    run_job('0, 4'b0001, 5, e, -1);

    run_job('0, 4'b0011, 1,
            {32'hFFFFFFF7, 32'h00000002, 32'h0000000D, 32'h0000000C,
             32'h0000000B, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC}, 0);

    s = '0;
    s[3*W +: W] = 32'h1;
    e = s;
    e[0 +: W] = 32'h00010000;
    run_job(s, 4'b0100, 1, e, 1);

    // Zero rounds with a long stall.
    s = {8{$urandom}};
    run_job(s, 4'hF, 0, s, 10);

    // Starts during RUN and in the handshake cycle must be ignored.
    s = {8{$urandom}};
    issue(s, 4'b1111, 6, model(s, 4'b1111, 6), 1'b0);
    tick();
    bus.seed = {8{$urandom}};
    bus.rounds = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid();
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    bus.rounds = 8'd2;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("no_second_job", vec_t'(bus.busy), vec_t'(0));
      tick();
    end

    // Reset in the third RUN cycle of a 10-round job.
    s = {8{$urandom}};
    issue(s, 4'b1011, 10, model(s, 4'b1011, 10), 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy", vec_t'(bus.busy), vec_t'(0));
    check("abort_valid", vec_t'(bus.out_valid), vec_t'(0));
    check("abort_result", bus.result, '0);
    s = {8{$urandom}};
    run_job(s, 4'b1011, 10, model(s, 4'b1011, 10), 2);

    for (int j = 0; j < 20; j++) begin
      logic [3:0] m;
      int r, st;
      s = {8{$urandom}};
      m = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 12);
      st = $urandom_range(0, 4) - 1;
      run_job(s, m, r, model(s, m, r), st);
    end

    tick(); tick();
    check("queue_drained", vec_t'(exp_q.size()), vec_t'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
